// File: rtl/adc_stream_pack.sv
// Joins NUM_CH per-channel sample streams, keeps the enabled channels, interleaves
// them sample-major and packs the result into OUT_W-bit beats framed by tlast.
module adc_stream_pack #(
    parameter int NUM_CH = 6,
    parameter int SAMP_W = 8,
    parameter int SPW    = 4,
    parameter int OUT_W  = 128
) (
    input  logic                         ps_clk,
    input  logic                         ps_rst,
    input  logic [NUM_CH-1:0]            s_tvalid,
    output logic [NUM_CH-1:0]            s_tready,
    input  logic [NUM_CH*SPW*SAMP_W-1:0] s_tdata,
    output logic                         m_tvalid,
    input  logic                         m_tready,
    output logic [OUT_W-1:0]             m_tdata,
    output logic                         m_tlast,
    input  logic                         start,
    input  logic                         abort,
    input  logic [NUM_CH-1:0]            ch_en,
    input  logic [31:0]                  frame_beats,
    output logic                         busy,
    output logic                         done,
    output logic                         cfg_err,
    output logic [31:0]                  beat_cnt
);
    localparam int OUT_S  = OUT_W / SAMP_W;
    localparam int IN_S   = NUM_CH * SPW;
    localparam int BUF_S  = OUT_S + IN_S;
    localparam int BUF_W  = BUF_S * SAMP_W;
    localparam int FILL_W = $clog2(BUF_S + 1);
    localparam int NEED_W = 32 + $clog2(OUT_S) + 1;
    localparam logic [FILL_W-1:0] OUT_SF = FILL_W'(OUT_S);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                     state, state_nxt;
    logic [BUF_W-1:0]           pbuf, pbuf_nxt;
    logic [FILL_W-1:0]          fill, fill_nxt, fill_ap, in_cnt;
    logic [NEED_W-1:0]          need, need_nxt, take;
    logic [NUM_CH-1:0]          en_q, en_nxt;
    logic [31:0]                beats_q, beats_nxt, cnt_nxt;
    logic                       done_nxt, err_nxt;
    logic [IN_S*SAMP_W-1:0]     merged;
    logic                       pop, room, all_vld, fire;

    // Sample-major merge of the enabled channels; element 0 lands at the lowest position.
    always_comb begin
        merged = '0;
        in_cnt = '0;
        for (int k = 0; k < SPW; k++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (en_q[c]) begin
                    merged[in_cnt*SAMP_W +: SAMP_W] = s_tdata[(c*SPW+k)*SAMP_W +: SAMP_W];
                    in_cnt = in_cnt + 1'b1;
                end
            end
        end
    end

    assign m_tvalid = (state == RUN) && (fill >= OUT_SF);
    assign m_tdata  = pbuf[OUT_W-1:0];
    assign m_tlast  = m_tvalid && (beat_cnt == beats_q - 32'd1);
    assign busy     = (state == RUN);

    assign pop      = m_tvalid && m_tready;
    assign fill_ap  = pop ? fill - OUT_SF : fill;
    assign room     = fill_ap < OUT_SF;
    assign all_vld  = &(s_tvalid | ~en_q);
    assign fire     = (state == RUN) && (need != '0) && room && all_vld;
    assign take     = (NEED_W'(in_cnt) > need) ? need : NEED_W'(in_cnt);
    // Disabled channels drain freely while running so their FIFOs never back up.
    assign s_tready = (state == RUN) ? (fire ? {NUM_CH{1'b1}} : ~en_q) : '0;

    always_comb begin
        state_nxt = state;
        pbuf_nxt  = pbuf;
        fill_nxt  = fill;
        need_nxt  = need;
        en_nxt    = en_q;
        beats_nxt = beats_q;
        cnt_nxt   = beat_cnt;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (ch_en == '0 || frame_beats == '0) begin
                        err_nxt = 1'b1;
                    end else begin
                        en_nxt    = ch_en;
                        beats_nxt = frame_beats;
                        need_nxt  = NEED_W'(frame_beats) * NEED_W'(OUT_S);
                        cnt_nxt   = '0;
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                    pbuf_nxt  = '0;
                    fill_nxt  = '0;
                end else begin
                    if (pop) cnt_nxt = beat_cnt + 32'd1;
                    if (pop && m_tlast) begin
                        // Surplus samples past the frame end are dropped here.
                        state_nxt = IDLE;
                        pbuf_nxt  = '0;
                        fill_nxt  = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        pbuf_nxt = pop ? (pbuf >> OUT_W) : pbuf;
                        fill_nxt = fill_ap;
                        if (fire) begin
                            pbuf_nxt = pbuf_nxt | (BUF_W'(merged) << (fill_ap * SAMP_W));
                            fill_nxt = fill_ap + in_cnt;
                            need_nxt = need - take;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ps_clk) begin
        if (ps_rst) begin
            state    <= IDLE;
            pbuf     <= '0;
            fill     <= '0;
            need     <= '0;
            en_q     <= '0;
            beats_q  <= '0;
            beat_cnt <= '0;
            done     <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            pbuf     <= pbuf_nxt;
            fill     <= fill_nxt;
            need     <= need_nxt;
            en_q     <= en_nxt;
            beats_q  <= beats_nxt;
            beat_cnt <= cnt_nxt;
            done     <= done_nxt;
            cfg_err  <= err_nxt;
        end
    end
endmodule

// File: tb/tb_adc_stream_pack.sv
// Bench for adc_stream_pack: random and patterned frames checked against a
// byte-stream reference pack built from the channel data tables.
module tb_adc_stream_pack;
    localparam int NUM_CH = 6;
    localparam int SAMP_W = 8;
    localparam int SPW    = 4;
    localparam int OUT_W  = 128;
    localparam int OUT_S  = OUT_W / SAMP_W;
    localparam int WW     = SPW * SAMP_W;

    logic                         ps_clk = 1'b0;
    logic                         ps_rst = 1'b1;
    logic [NUM_CH-1:0]            s_tvalid = '0;
    logic [NUM_CH-1:0]            s_tready;
    logic [NUM_CH*WW-1:0]         s_tdata = '0;
    logic                         m_tvalid;
    logic                         m_tready = 1'b0;
    logic [OUT_W-1:0]             m_tdata;
    logic                         m_tlast;
    logic                         start = 1'b0;
    logic                         abort = 1'b0;
    logic [NUM_CH-1:0]            ch_en = '0;
    logic [31:0]                  frame_beats = '0;
    logic                         busy, done, cfg_err;
    logic [31:0]                  beat_cnt;

    adc_stream_pack #(.NUM_CH(NUM_CH), .SAMP_W(SAMP_W), .SPW(SPW), .OUT_W(OUT_W)) dut (
        .ps_clk(ps_clk), .ps_rst(ps_rst), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .s_tdata(s_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .m_tlast(m_tlast), .start(start), .abort(abort), .ch_en(ch_en),
        .frame_beats(frame_beats), .busy(busy), .done(done), .cfg_err(cfg_err),
        .beat_cnt(beat_cnt)
    );

    always #5 ps_clk = ~ps_clk;

    int total = 0;
    int bad   = 0;

    logic [WW-1:0]    wdata [NUM_CH][64];
    int               acc [NUM_CH];
    logic [OUT_W-1:0] got [$];
    logic             lasts [$];
    logic [OUT_W-1:0] expq [$];
    int               last_cyc, done_cyc, done_bad, stall_bad, dis_bad;
    bit               timeout, killed, first_busy;

    task automatic fill_data(input bit pattern);
        for (int c = 0; c < NUM_CH; c++)
            for (int w = 0; w < 64; w++)
                for (int k = 0; k < SPW; k++)
                    wdata[c][w][k*SAMP_W +: SAMP_W] = pattern ? 8'(c*16 + k) : 8'($urandom_range(255));
    endtask

    // Reference: concatenate enabled samples word by word, sample-major, then cut into beats.
    task automatic build_expected(input logic [NUM_CH-1:0] en, input int beats);
        logic [SAMP_W-1:0] bytes [$];
        logic [OUT_W-1:0]  beat;
        expq.delete();
        for (int w = 0; bytes.size() < beats*OUT_S; w++)
            for (int k = 0; k < SPW; k++)
                for (int c = 0; c < NUM_CH; c++)
                    if (en[c]) bytes.push_back(wdata[c][w][k*SAMP_W +: SAMP_W]);
        for (int b = 0; b < beats; b++) begin
            beat = '0;
            for (int i = 0; i < OUT_S; i++) beat[i*SAMP_W +: SAMP_W] = bytes[b*OUT_S + i];
            expq.push_back(beat);
        end
    endtask

    task automatic run_frame(input logic [NUM_CH-1:0] en, input int beats, input int rdy_pct,
                             input int vld_pct, input int kill_at, input bit use_rst);
        int cyc;
        bit prev_stall;
        logic [OUT_W-1:0] prev_data;
        logic prev_last;
        got.delete(); lasts.delete();
        for (int c = 0; c < NUM_CH; c++) acc[c] = 0;
        last_cyc = -1; done_cyc = -1; done_bad = 0; stall_bad = 0; dis_bad = 0;
        timeout = 0; killed = 0; prev_stall = 0; prev_data = '0; prev_last = 0; cyc = 0;
        @(negedge ps_clk);
        ch_en = en; frame_beats = beats; start = 1'b1;
        @(posedge ps_clk);
        while (1) begin
            @(negedge ps_clk);
            start = 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                s_tvalid[c] = ($urandom_range(99) < vld_pct);
                s_tdata[c*WW +: WW] = wdata[c][acc[c] % 64];
            end
            #1;
            if (cyc == 0) first_busy = busy;
            if (done) begin
                if (last_cyc >= 0) done_cyc = cyc; else done_bad++;
            end
            if (done_cyc >= 0) break;
            if (kill_at >= 0 && got.size() == kill_at && m_tvalid) begin
                m_tready = 1'b0;
                if (use_rst) ps_rst = 1'b1; else abort = 1'b1;
                killed = 1;
            end else begin
                m_tready = ($urandom_range(99) < rdy_pct);
            end
            #1;
            if (prev_stall && (!m_tvalid || m_tdata !== prev_data || m_tlast !== prev_last)) stall_bad++;
            for (int c = 0; c < NUM_CH; c++) begin
                if (s_tvalid[c] && s_tready[c]) acc[c]++;
                if (busy && !en[c] && !s_tready[c]) dis_bad++;
            end
            if (m_tvalid && m_tready) begin
                got.push_back(m_tdata);
                lasts.push_back(m_tlast);
                if (m_tlast) last_cyc = cyc;
            end
            prev_stall = m_tvalid && !m_tready;
            prev_data = m_tdata; prev_last = m_tlast;
            cyc++;
            @(posedge ps_clk);
            if (killed) break;
            if (last_cyc >= 0 && cyc > last_cyc + 4) break;
            if (cyc >= 2000) begin timeout = 1; break; end
        end
        s_tvalid = '0;
        m_tready = 1'b0;
    endtask

    task automatic test_reset;
        ps_rst = 1'b1; s_tvalid = '1;
        repeat (3) @(posedge ps_clk);
        @(negedge ps_clk); #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (m_tvalid !== 1'b0 || m_tlast !== 1'b0) begin bad++; $display("FAIL reset_mvalid got=%b/%b want=0/0", m_tvalid, m_tlast); end
        total++; if (m_tdata !== '0) begin bad++; $display("FAIL reset_mdata got=%h want=0", m_tdata); end
        total++; if (beat_cnt !== 32'd0 || done !== 1'b0 || cfg_err !== 1'b0) begin bad++; $display("FAIL reset_status cnt=%0d done=%b err=%b want 0", beat_cnt, done, cfg_err); end
        total++; if (s_tready !== '0) begin bad++; $display("FAIL reset_sready got=%b want=0", s_tready); end
        ps_rst = 1'b0; s_tvalid = '0;
        @(negedge ps_clk);
    endtask

    task automatic test_all_channels;
        fill_data(1);
        build_expected(6'h3f, 3);
        run_frame(6'h3f, 3, 100, 100, -1, 0);
        total++; if (timeout) begin bad++; $display("FAIL all_timeout got=timeout want=done"); end
        total++; if (first_busy !== 1'b1) begin bad++; $display("FAIL all_busy got=%b want=1", first_busy); end
        total++; if (got.size() != 3) begin bad++; $display("FAIL all_nbeats got=%0d want=3", got.size()); end
        total++; if (got.size() > 0 && got[0] !== 128'h32221202_51413121_11015040_30201000)
            begin bad++; $display("FAIL all_beat0 got=%h want=32221202514131211101504030201000", got[0]); end
        for (int b = 0; b < got.size(); b++) begin
            total++; if (got[b] !== expq[b] || lasts[b] !== (b == 2)) begin
                bad++; $display("FAIL all_beat%0d got=%h/%b want=%h/%b", b, got[b], lasts[b], expq[b], b == 2); end
        end
        total++; if (done_cyc != last_cyc + 1 || done_bad != 0) begin bad++; $display("FAIL all_done got=%0d want=%0d", done_cyc, last_cyc + 1); end
        total++; if (acc[0] != 2) begin bad++; $display("FAIL all_words got=%0d want=2", acc[0]); end
        total++; if (beat_cnt !== 32'd3 || busy !== 1'b0) begin bad++; $display("FAIL all_end cnt=%0d busy=%b want 3/0", beat_cnt, busy); end
    endtask

    task automatic test_masked;
        fill_data(0);
        build_expected(6'b000101, 2);
        run_frame(6'b000101, 2, 100, 100, -1, 0);
        total++; if (got.size() != 2 || timeout) begin bad++; $display("FAIL mask_nbeats got=%0d want=2", got.size()); end
        for (int b = 0; b < got.size(); b++) begin
            total++; if (got[b] !== expq[b] || lasts[b] !== (b == 1)) begin
                bad++; $display("FAIL mask_beat%0d got=%h/%b want=%h/%b", b, got[b], lasts[b], expq[b], b == 1); end
        end
        total++; if (acc[0] != 4 || acc[2] != 4) begin bad++; $display("FAIL mask_words got=%0d,%0d want=4,4", acc[0], acc[2]); end
        total++; if (dis_bad != 0) begin bad++; $display("FAIL mask_dis_ready got=%0d want=0", dis_bad); end
        total++; if (done_cyc != last_cyc + 1) begin bad++; $display("FAIL mask_done got=%0d want=%0d", done_cyc, last_cyc + 1); end
    endtask

    task automatic test_random_stall;
        logic [NUM_CH-1:0] en;
        int beats, nen, words, fc;
        for (int it = 0; it < 5; it++) begin
            fill_data(0);
            en = NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
            beats = $urandom_range(1, 10);
            nen = $countones(en);
            words = (beats*OUT_S + nen*SPW - 1) / (nen*SPW);
            fc = 0;
            while (!en[fc]) fc++;
            build_expected(en, beats);
            run_frame(en, beats, 50, 70, -1, 0);
            total++; if (got.size() != beats || timeout) begin bad++; $display("FAIL rnd%0d_nbeats got=%0d want=%0d", it, got.size(), beats); end
            for (int b = 0; b < got.size(); b++) begin
                total++; if (got[b] !== expq[b] || lasts[b] !== (b == beats - 1)) begin
                    bad++; $display("FAIL rnd%0d_beat%0d got=%h want=%h", it, b, got[b], expq[b]); end
            end
            total++; if (stall_bad != 0) begin bad++; $display("FAIL rnd%0d_stall got=%0d want=0", it, stall_bad); end
            total++; if (acc[fc] != words) begin bad++; $display("FAIL rnd%0d_words got=%0d want=%0d", it, acc[fc], words); end
            total++; if (dis_bad != 0 || done_cyc != last_cyc + 1) begin bad++; $display("FAIL rnd%0d_ctrl dis=%0d done=%0d want 0/%0d", it, dis_bad, done_cyc, last_cyc + 1); end
        end
    endtask

    task automatic test_cfg_err;
        for (int t = 0; t < 2; t++) begin
            @(negedge ps_clk);
            ch_en = (t == 0) ? '0 : 6'h3f;
            frame_beats = (t == 0) ? 32'd4 : 32'd0;
            start = 1'b1; s_tvalid = '1;
            @(posedge ps_clk);
            @(negedge ps_clk);
            start = 1'b0; #1;
            total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL cfg%0d_err got=%b want=1", t, cfg_err); end
            total++; if (busy !== 1'b0 || s_tready !== '0) begin bad++; $display("FAIL cfg%0d_idle busy=%b rdy=%b want 0/0", t, busy, s_tready); end
            @(negedge ps_clk); #1;
            total++; if (cfg_err !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL cfg%0d_pulse err=%b busy=%b want 0/0", t, cfg_err, busy); end
        end
        s_tvalid = '0;
    endtask

    task automatic test_abort;
        fill_data(0);
        run_frame(6'h3f, 8, 100, 100, 1, 0);
        total++; if (!killed) begin bad++; $display("FAIL abort_reached got=0 want=1"); end
        @(negedge ps_clk);
        abort = 1'b0; #1;
        total++; if (busy !== 1'b0 || m_tvalid !== 1'b0) begin bad++; $display("FAIL abort_idle busy=%b vld=%b want 0/0", busy, m_tvalid); end
        total++; if (beat_cnt !== 32'd1) begin bad++; $display("FAIL abort_cnt got=%0d want=1", beat_cnt); end
        repeat (3) begin
            total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done got=%b want=0", done); end
            @(negedge ps_clk); #1;
        end
        fill_data(0);
        build_expected(6'h3f, 8);
        run_frame(6'h3f, 8, 100, 100, -1, 0);
        total++; if (got.size() != 8 || timeout) begin bad++; $display("FAIL abort_next_n got=%0d want=8", got.size()); end
        for (int b = 0; b < got.size(); b++) begin
            total++; if (got[b] !== expq[b] || lasts[b] !== (b == 7)) begin
                bad++; $display("FAIL abort_next_beat%0d got=%h want=%h", b, got[b], expq[b]); end
        end
    endtask

    task automatic test_reset_mid;
        fill_data(0);
        run_frame(6'h3f, 6, 100, 100, 2, 1);
        @(negedge ps_clk);
        ps_rst = 1'b0; #1;
        total++; if (!killed || busy !== 1'b0 || m_tvalid !== 1'b0 || m_tlast !== 1'b0) begin
            bad++; $display("FAIL rstmid_ctrl hit=%b busy=%b vld=%b want 1/0/0", killed, busy, m_tvalid); end
        total++; if (m_tdata !== '0 || beat_cnt !== 32'd0 || s_tready !== '0 || done !== 1'b0) begin
            bad++; $display("FAIL rstmid_outs data=%h cnt=%0d rdy=%b done=%b want 0", m_tdata, beat_cnt, s_tready, done); end
        fill_data(0);
        build_expected(6'b110011, 3);
        run_frame(6'b110011, 3, 80, 90, -1, 0);
        total++; if (got.size() != 3 || timeout) begin bad++; $display("FAIL rstmid_next_n got=%0d want=3", got.size()); end
        for (int b = 0; b < got.size(); b++) begin
            total++; if (got[b] !== expq[b]) begin
                bad++; $display("FAIL rstmid_next_beat%0d got=%h want=%h", b, got[b], expq[b]); end
        end
    endtask

    initial begin
        test_reset();
        test_all_channels();
        test_masked();
        test_random_stall();
        test_cfg_err();
        test_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
